pipe_cpu_core: RTL and testbench

//  Parametrised 4-stage in-order core (IF, RD, EX, WB): NUM_REGS-entry register file, internal data RAM, external instruction ROM port.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/cpu_regfile.sv | 28 ++
 rtl/pipe_cpu_core.sv | 125 ++++++++++++
 tb/tb_pipe_cpu_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes and decode helpers shared by the pipe_cpu_core slice
package cpu_pkg;
  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_INCR      = 4'd1;
  localparam logic [3:0] OP_MULT      = 4'd2;
  localparam logic [3:0] OP_LOAD      = 4'd3;
  localparam logic [3:0] OP_WRITE_R   = 4'd6;
  localparam logic [3:0] OP_WRITE_MEM = 4'd7;
  localparam logic [3:0] OP_JGZ       = 4'd9;
  localparam logic [3:0] OP_JUMP      = 4'd10;
  localparam logic [3:0] OP_JNEQ      = 4'd11;
  localparam logic [3:0] OP_HALT      = 4'd12;
  function automatic logic writes_reg(input logic [3:0] op);
    return op == OP_INCR || op == OP_MULT || op == OP_LOAD;
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op == OP_WRITE_R || op == OP_WRITE_MEM;
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: write-through register file, two operand ports plus a debug port
module cpu_regfile #(
  parameter  int DW       = 16,
  parameter  int NUM_REGS = 4,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [RW-1:0] wsel_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [RW-1:0] asel_i,
  input  logic [RW-1:0] bsel_i,
  input  logic [RW-1:0] dsel_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [DW-1:0] d_o
);
  logic [DW-1:0] r_q [NUM_REGS];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NUM_REGS; i++) r_q[i] <= '0;
    else if (we_i) r_q[wsel_i] <= wdata_i;
  always_comb begin
    a_o = (we_i && wsel_i == asel_i) ? wdata_i : r_q[asel_i];
    b_o = (we_i && wsel_i == bsel_i) ? wdata_i : r_q[bsel_i];
    d_o = (we_i && wsel_i == dsel_i) ? wdata_i : r_q[dsel_i];
  end
endmodule

// File: rtl/pipe_cpu_core.sv
// pipe_cpu_core: 4-stage IF/RD/EX/WB core with full forwarding, branch flush and HALT
module pipe_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DW       = 16,
  parameter  int NUM_REGS = 4,
  parameter  int PAW      = 10,
  parameter  int DAW      = 13,
  localparam int RW       = $clog2(NUM_REGS),
  localparam int INSTR_W  = 4 + 2*RW + DAW + DW
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PAW-1:0]     imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               halted,
  output logic               retire_valid,
  output logic [PAW-1:0]     retire_pc,
  input  logic [RW-1:0]      dbg_sel,
  output logic [DW-1:0]      dbg_data
);
  logic [PAW-1:0] pc_q, pc_d;
  logic           halted_q;
  logic               rd_v_q;
  logic [PAW-1:0]     rd_pc_q;
  logic [INSTR_W-1:0] rd_ins_q;
  logic [3:0]         rd_op;
  logic [RW-1:0]      rd_ra, rd_rb;
  logic [DAW-1:0]     rd_addr;
  logic [DW-1:0]      rd_lit, rd_a, rd_b, rd_ld;
  logic           ex_v_q;
  logic [PAW-1:0] ex_pc_q;
  logic [3:0]     ex_op_q;
  logic [RW-1:0]  ex_ra_q, ex_rb_q;
  logic [DAW-1:0] ex_addr_q;
  logic [DW-1:0]  ex_lit_q, ex_a_q, ex_b_q, ex_ld_q;
  logic [DW-1:0]  ex_a, ex_b, ex_ld, ex_res_d;
  logic           taken, freeze, flush;
  logic           wb_v_q, wb_wr, wb_st, wb_halt;
  logic [PAW-1:0] wb_pc_q;
  logic [3:0]     wb_op_q;
  logic [RW-1:0]  wb_ra_q;
  logic [DAW-1:0] wb_addr_q;
  logic [DW-1:0]  wb_res_q;
  logic [DW-1:0]  mem [2**DAW];
  assign {rd_op, rd_ra, rd_rb, rd_addr, rd_lit} = rd_ins_q;
  cpu_regfile #(.DW(DW), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .reset(reset),
    .we_i(wb_wr), .wsel_i(wb_ra_q), .wdata_i(wb_res_q),
    .asel_i(rd_ra), .bsel_i(rd_rb), .dsel_i(dbg_sel),
    .a_o(rd_a), .b_o(rd_b), .d_o(dbg_data)
  );
  always_comb begin
    wb_wr    = wb_v_q && writes_reg(wb_op_q);
    wb_st    = wb_v_q && is_store(wb_op_q);
    wb_halt  = wb_v_q && wb_op_q == OP_HALT;
    rd_ld    = (wb_st && wb_addr_q == rd_addr) ? wb_res_q : mem[rd_addr];
    ex_a     = (wb_wr && wb_ra_q == ex_ra_q) ? wb_res_q : ex_a_q;
    ex_b     = (wb_wr && wb_ra_q == ex_rb_q) ? wb_res_q : ex_b_q;
    ex_ld    = (wb_st && wb_addr_q == ex_addr_q) ? wb_res_q : ex_ld_q;
    ex_res_d = ex_op_q == OP_INCR    ? ex_a + DW'(1) :
               ex_op_q == OP_MULT    ? ex_a * ex_b :
               ex_op_q == OP_LOAD    ? ex_ld :
               ex_op_q == OP_WRITE_R ? ex_a : ex_lit_q;
    taken    = ex_v_q && (ex_op_q == OP_JUMP || (ex_op_q == OP_JGZ && ex_a > ex_b) ||
                          (ex_op_q == OP_JNEQ && ex_a != ex_b));
    // a HALT anywhere past RD stops fetch until reset
    freeze   = halted_q || (ex_v_q && ex_op_q == OP_HALT) || wb_halt;
    flush    = taken || freeze;
    pc_d     = taken ? ex_addr_q[PAW-1:0] : freeze ? pc_q : pc_q + PAW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q      <= '0;
      halted_q  <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_pc_q   <= '0;
      rd_ins_q  <= '0;
      ex_v_q    <= 1'b0;
      ex_pc_q   <= '0;
      ex_op_q   <= OP_NOP;
      ex_ra_q   <= '0;
      ex_rb_q   <= '0;
      ex_addr_q <= '0;
      ex_lit_q  <= '0;
      ex_a_q    <= '0;
      ex_b_q    <= '0;
      ex_ld_q   <= '0;
      wb_v_q    <= 1'b0;
      wb_pc_q   <= '0;
      wb_op_q   <= OP_NOP;
      wb_ra_q   <= '0;
      wb_addr_q <= '0;
      wb_res_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      halted_q  <= halted_q || wb_halt;
      rd_v_q    <= !flush;
      rd_pc_q   <= pc_q;
      rd_ins_q  <= imem_rdata;
      ex_v_q    <= rd_v_q && !flush;
      ex_pc_q   <= rd_pc_q;
      ex_op_q   <= rd_op;
      ex_ra_q   <= rd_ra;
      ex_rb_q   <= rd_rb;
      ex_addr_q <= rd_addr;
      ex_lit_q  <= rd_lit;
      ex_a_q    <= rd_a;
      ex_b_q    <= rd_b;
      ex_ld_q   <= rd_ld;
      wb_v_q    <= ex_v_q;
      wb_pc_q   <= ex_pc_q;
      wb_op_q   <= ex_op_q;
      wb_ra_q   <= ex_ra_q;
      wb_addr_q <= ex_addr_q;
      wb_res_q  <= ex_res_d;
    end
  // RAM keeps its contents across reset, but a store caught by reset must not land
  always_ff @(posedge clk)
    if (!reset && wb_st) mem[wb_addr_q] <= wb_res_q;
  assign imem_addr    = pc_q;
  assign halted       = halted_q;
  assign retire_valid = wb_v_q;
  assign retire_pc    = wb_pc_q;
endmodule

// File: tb/tb_pipe_cpu_core.sv
// tb_pipe_cpu_core: directed and random programs checked against an ISA-level interpreter
module tb_pipe_cpu_core;
  localparam int DW = 16, NR = 4, PAW = 10, DAW = 13, RW = 2, IW = 4 + 2*RW + DAW + DW;
  localparam logic [3:0] RND_OPS [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd4, 4'd13, 4'd15};
  logic clk = 1'b0;
  logic reset;
  logic [PAW-1:0] imem_addr, retire_pc;
  logic [IW-1:0] imem_rdata;
  logic halted, retire_valid;
  logic [RW-1:0] dbg_sel;
  logic [DW-1:0] dbg_data;
  logic [IW-1:0] rom [1024];
  logic [15:0] m_reg [4];
  logic [15:0] m_mem [8192];
  int exp_pcs[$];
  int exp_taken;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  assign imem_rdata = rom[imem_addr];
  pipe_cpu_core #(.DW(DW), .NUM_REGS(NR), .PAW(PAW), .DAW(DAW)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .halted(halted), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [IW-1:0] enc(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                                        input logic [12:0] ad, input logic [15:0] lit);
    return {op, ra, rb, ad, lit};
  endfunction
  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = enc(4'd1, 2'd3, 2'd0, 13'd0, 16'd0);
  endtask
  task automatic chk_reg(input string tag, input int r, input logic [15:0] v);
    dbg_sel = 2'(r);
    #1;
    chk(tag, 32'(dbg_data), 32'(v));
  endtask
  // Sequential interpreter: architectural effect of the program, one instruction at a time
  task automatic model_run();
    logic [9:0] pc;
    logic [3:0] op;
    logic [1:0] ra, rb;
    logic [12:0] ad;
    logic [15:0] lit;
    bit done, jmp;
    exp_pcs.delete();
    exp_taken = 0;
    pc = 10'd0;
    done = 1'b0;
    for (int r = 0; r < 4; r++) m_reg[r] = 16'd0;
    for (int s = 0; s < 3000 && !done; s++) begin
      {op, ra, rb, ad, lit} = rom[pc];
      exp_pcs.push_back(int'(pc));
      jmp = 1'b0;
      case (op)
        4'd1:  m_reg[ra] = m_reg[ra] + 16'd1;
        4'd2:  m_reg[ra] = m_reg[ra] * m_reg[rb];
        4'd3:  m_reg[ra] = m_mem[ad];
        4'd6:  m_mem[ad] = m_reg[ra];
        4'd7:  m_mem[ad] = lit;
        4'd9:  jmp = m_reg[ra] > m_reg[rb];
        4'd10: jmp = 1'b1;
        4'd11: jmp = m_reg[ra] != m_reg[rb];
        4'd12: done = 1'b1;
        default: ;
      endcase
      if (jmp) exp_taken++;
      pc = jmp ? ad[9:0] : pc + 10'd1;
    end
  endtask
  task automatic run_prog(input string tag);
    int act[$];
    int hc;
    logic [PAW-1:0] a0;
    model_run();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    hc = -1;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge clk);
      #1;
      if (retire_valid) act.push_back(int'(retire_pc));
      if (halted) begin
        hc = c;
        break;
      end
    end
    chk({tag, ".cycles"}, 32'(hc), 32'(exp_pcs.size() + 3 + 2*exp_taken));
    chk({tag, ".retires"}, 32'(act.size()), 32'(exp_pcs.size()));
    for (int i = 0; i < exp_pcs.size() && i < act.size(); i++)
      chk($sformatf("%s.pc%0d", tag, i), 32'(act[i]), 32'(exp_pcs[i]));
    a0 = imem_addr;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".frozen"}, {30'd0, retire_valid, halted}, 32'd1);
    chk({tag, ".pc_hold"}, 32'(imem_addr), 32'(a0));
    for (int r = 0; r < 4; r++) chk_reg($sformatf("%s.R%0d", tag, r), r, m_reg[r]);
  endtask
  task automatic load_t1();
    clear_rom();
    rom[0] = enc(4'd7, 2'd0, 2'd0, 13'd5, 16'd7);
    rom[1] = enc(4'd3, 2'd0, 2'd0, 13'd5, 16'd0);
    rom[2] = enc(4'd1, 2'd0, 2'd0, 13'd0, 16'd0);
    rom[3] = enc(4'd6, 2'd0, 2'd0, 13'd6, 16'd0);
    rom[4] = enc(4'd12, 2'd0, 2'd0, 13'd0, 16'd0);
  endtask
  task automatic gen_random();
    int h, t;
    logic [3:0] op;
    logic [12:0] ad;
    clear_rom();
    for (int a = 0; a < 8; a++)
      rom[a] = enc(4'd7, 2'd0, 2'd0, 13'(a), a < 4 ? 16'($urandom_range(0, 3)) : 16'($urandom));
    for (int r = 0; r < 4; r++) rom[8+r] = enc(4'd3, 2'(r), 2'd0, 13'($urandom_range(0, 7)), 16'd0);
    h = 32;
    for (int i = 12; i < h; i++) begin
      op = RND_OPS[$urandom_range(0, 11)];
      if (op == 4'd9 || op == 4'd10 || op == 4'd11) begin
        t = i + 1 + int'($urandom_range(1, 3));
        ad = 13'(t > h ? h : t);
      end else ad = 13'($urandom_range(0, 7));
      rom[i] = enc(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ad, 16'($urandom));
    end
    rom[h] = enc(4'd12, 2'd0, 2'd0, 13'd0, 16'd0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog expired: observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b0;
    dbg_sel = '0;
    clear_rom();
    #3 reset = 1'b1;
    #1;
    chk("rst.pc", 32'(imem_addr), 32'd0);
    chk("rst.retire", {31'd0, retire_valid}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.retire_pc", 32'(retire_pc), 32'd0);
    chk_reg("rst.R0", 0, 16'd0);
    @(negedge clk) reset = 1'b0;
    load_t1();
    run_prog("t1");
    chk_reg("t1.R0_is_8", 0, 16'd8);
    #2 reset = 1'b1;
    #1;
    chk("t1rst.halted", {31'd0, halted}, 32'd0);
    chk("t1rst.pc", 32'(imem_addr), 32'd0);
    @(negedge clk) reset = 1'b0;
    clear_rom();
    rom[0] = enc(4'd3, 2'd1, 2'd0, 13'd6, 16'd0);
    rom[1] = enc(4'd12, 2'd0, 2'd0, 13'd0, 16'd0);
    run_prog("t1d6");
    chk_reg("t1d6.D6_is_8", 1, 16'd8);
    clear_rom();
    rom[0] = enc(4'd7, 2'd0, 2'd0, 13'd0, 16'd3);
    rom[1] = enc(4'd7, 2'd0, 2'd0, 13'd1, 16'd4);
    rom[2] = enc(4'd3, 2'd1, 2'd0, 13'd0, 16'd0);
    rom[3] = enc(4'd3, 2'd2, 2'd0, 13'd1, 16'd0);
    rom[4] = enc(4'd2, 2'd1, 2'd2, 13'd0, 16'd0);
    rom[5] = enc(4'd12, 2'd0, 2'd0, 13'd0, 16'd0);
    run_prog("t2a");
    chk_reg("t2a.R1_is_12", 1, 16'd12);
    rom[0] = enc(4'd7, 2'd0, 2'd0, 13'd2, 16'hFFFF);
    rom[1] = enc(4'd7, 2'd0, 2'd0, 13'd3, 16'd2);
    rom[2] = enc(4'd3, 2'd1, 2'd0, 13'd2, 16'd0);
    rom[3] = enc(4'd3, 2'd2, 2'd0, 13'd3, 16'd0);
    run_prog("t2b");
    chk_reg("t2b.R1_is_FFFE", 1, 16'hFFFE);
    clear_rom();
    rom[0] = enc(4'd10, 2'd0, 2'd0, 13'd20, 16'd0);
    rom[1] = enc(4'd1, 2'd0, 2'd0, 13'd0, 16'd0);
    rom[2] = enc(4'd1, 2'd0, 2'd0, 13'd0, 16'd0);
    rom[20] = enc(4'd12, 2'd0, 2'd0, 13'd0, 16'd0);
    run_prog("t3");
    chk_reg("t3.R0_is_0", 0, 16'd0);
    clear_rom();
    rom[0] = enc(4'd7, 2'd0, 2'd0, 13'd0, 16'd5);
    rom[1] = enc(4'd3, 2'd1, 2'd0, 13'd0, 16'd0);
    rom[2] = enc(4'd1, 2'd0, 2'd0, 13'd0, 16'd0);
    rom[3] = enc(4'd11, 2'd0, 2'd1, 13'd2, 16'd0);
    rom[4] = enc(4'd9, 2'd0, 2'd1, 13'd10, 16'd0);
    rom[5] = enc(4'd1, 2'd2, 2'd0, 13'd0, 16'd0);
    rom[6] = enc(4'd12, 2'd0, 2'd0, 13'd0, 16'd0);
    rom[10] = enc(4'd12, 2'd0, 2'd0, 13'd0, 16'd0);
    run_prog("t4");
    chk_reg("t4.R0_is_5", 0, 16'd5);
    chk_reg("t4.R2_is_1", 2, 16'd1);
    chk_reg("t4.R3_is_0", 3, 16'd0);
    clear_rom();
    rom[0] = enc(4'd7, 2'd0, 2'd0, 13'd9, 16'h00AA);
    rom[1] = enc(4'd3, 2'd3, 2'd0, 13'd9, 16'd0);
    rom[2] = enc(4'd1, 2'd2, 2'd0, 13'd0, 16'd0);
    rom[3] = enc(4'd6, 2'd2, 2'd0, 13'd10, 16'd0);
    rom[4] = enc(4'd3, 2'd1, 2'd0, 13'd10, 16'd0);
    rom[5] = enc(4'd7, 2'd0, 2'd0, 13'd11, 16'd5);
    rom[6] = enc(4'd0, 2'd0, 2'd0, 13'd0, 16'd0);
    rom[7] = enc(4'd3, 2'd0, 2'd0, 13'd11, 16'd0);
    rom[8] = enc(4'd12, 2'd0, 2'd0, 13'd0, 16'd0);
    run_prog("t5");
    chk_reg("t5.R3_is_AA", 3, 16'h00AA);
    chk_reg("t5.R1_is_1", 1, 16'd1);
    chk_reg("t5.R0_is_5", 0, 16'd5);
    for (int k = 0; k < 20; k++) begin
      gen_random();
      run_prog($sformatf("rnd%0d", k));
    end
    clear_rom();
    rom[0] = enc(4'd1, 2'd0, 2'd0, 13'd0, 16'd0);
    rom[1] = enc(4'd10, 2'd0, 2'd0, 13'd0, 16'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    dbg_sel = 2'd0;
    #1;
    chk("t6.R0_running", {31'd0, dbg_data != 16'd0}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6.pc", 32'(imem_addr), 32'd0);
    chk("t6.retire", {31'd0, retire_valid}, 32'd0);
    chk("t6.halted", {31'd0, halted}, 32'd0);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("t6.R%0d", r), r, 16'd0);
    @(negedge clk) reset = 1'b0;
    load_t1();
    run_prog("t6.rerun");
    chk_reg("t6.R0_is_8", 0, 16'd8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
